// File: rtl/dac_scan_pkg.sv
// Shared types and default sizing for the DAC scan writer.
package dac_scan_pkg;

  localparam int DEF_DATA_W       = 12;
  localparam int DEF_CH_NUM       = 16;
  localparam int DEF_CLK_DIV      = 16;
  localparam int DEF_SETTLE_TICKS = 10;
  localparam int DEF_HOLD_TICKS   = 4;

  // One code-to-output pass per channel walks SELECT through HOLD in order
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LOAD   = 3'd2,
    STROBE = 3'd3,
    LATCH  = 3'd4,
    SETTLE = 3'd5,
    HOLD   = 3'd6
  } scan_state_t;

endpackage

// File: rtl/dac_scan_writer_scan_tick_gen.sv
// Free-running divider producing a one-CLK tick every CLK_DIV cycles.
module scan_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic CLK,
  input  logic RSTn,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/dac_scan_writer.sv
// Multi-channel DAC refresh engine: host register file plus a tick-paced scan FSM.
// Optional host readback port is enabled by defining DAC_SCAN_READBACK_EN.
module dac_scan_writer
  import dac_scan_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CH_NUM       = DEF_CH_NUM,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int SETTLE_TICKS = DEF_SETTLE_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Scan_En,
  input  logic              Write,
  input  logic [3:0]        Channel_Select,
  input  logic [DATA_W-1:0] Wr_Data,
`ifdef DAC_SCAN_READBACK_EN
  input  logic              Read,
  output logic [DATA_W-1:0] Rd_Data,
`endif
  output logic              Ack,
  output logic              Busy,
  output logic [DATA_W-1:0] DAC_DATA,
  output logic              DAC_CSn,
  output logic              DAC_WRn,
  output logic [3:0]        Analog_Switch,
  output logic              SH_EN
);

  localparam int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PH_MAX = (SETTLE_TICKS > HOLD_TICKS) ? SETTLE_TICKS : HOLD_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  logic              tick;
  logic [DATA_W-1:0] mem [CH_NUM];
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;

  scan_state_t       state;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [PH_W-1:0]   phase_cnt;
  logic              settle_last;
  logic              hold_last;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RSTn (RSTn),
    .tick (tick)
  );

  assign sel_valid   = (32'(Channel_Select) < 32'(CH_NUM));
  assign sel_idx     = Channel_Select[IDX_W-1:0];
  assign next_idx    = (scan_idx == IDX_W'(CH_NUM - 1)) ? '0 : scan_idx + IDX_W'(1);
  assign settle_last = (phase_cnt == PH_W'(SETTLE_TICKS - 1));
  assign hold_last   = (phase_cnt == PH_W'(HOLD_TICKS - 1));

  // Host writes always win the port; out-of-range channels are acknowledged but dropped
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < CH_NUM; i++) begin
        mem[i] <= '0;
      end
      Ack <= 1'b0;
    end else begin
      Ack <= Write;
      if (Write && sel_valid) begin
        mem[sel_idx] <= Wr_Data;
      end
    end
  end

`ifdef DAC_SCAN_READBACK_EN
  // Write-first: a read colliding with a write to the same entry returns the new code
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Rd_Data <= '0;
    end else if (Read && sel_valid) begin
      Rd_Data <= Write ? Wr_Data : mem[sel_idx];
    end else begin
      Rd_Data <= '0;
    end
  end
`else
  // Readback disabled: the register file is write-only from the host side.
`endif

  // Scan sequencer; every output is registered and changes on the edge its state is entered
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= IDLE;
      scan_idx      <= '0;
      phase_cnt     <= '0;
      DAC_DATA      <= '0;
      DAC_CSn       <= 1'b1;
      DAC_WRn       <= 1'b1;
      Analog_Switch <= '0;
      SH_EN         <= 1'b0;
      Busy          <= 1'b0;
    end else if (!(state inside {IDLE, SELECT, LOAD, STROBE, LATCH, SETTLE, HOLD})) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      DAC_DATA      <= '0;
      DAC_CSn       <= 1'b1;
      DAC_WRn       <= 1'b1;
      Analog_Switch <= '0;
      SH_EN         <= 1'b0;
      Busy          <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          DAC_CSn <= 1'b1;
          DAC_WRn <= 1'b1;
          SH_EN   <= 1'b0;
          if (Scan_En) begin
            state         <= SELECT;
            Analog_Switch <= 4'(scan_idx);
            Busy          <= 1'b1;
          end
        end
        SELECT: begin
          state    <= LOAD;
          DAC_DATA <= mem[scan_idx];
          DAC_CSn  <= 1'b0;
        end
        LOAD: begin
          state   <= STROBE;
          DAC_WRn <= 1'b0;
        end
        STROBE: begin
          state   <= LATCH;
          DAC_WRn <= 1'b1;
          DAC_CSn <= 1'b1;
        end
        LATCH: begin
          state     <= SETTLE;
          phase_cnt <= '0;
        end
        SETTLE: begin
          if (settle_last) begin
            state     <= HOLD;
            SH_EN     <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        HOLD: begin
          if (hold_last) begin
            SH_EN     <= 1'b0;
            scan_idx  <= next_idx;
            phase_cnt <= '0;
            // Scan_En is only consulted here, so a channel in flight always completes
            if (Scan_En) begin
              state         <= SELECT;
              Analog_Switch <= 4'(next_idx);
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_scan_writer.sv
// Self-checking bench for dac_scan_writer; readback checks run when DAC_SCAN_READBACK_EN is defined.
module tb_dac_scan_writer;

  localparam int DW     = 12;
  localparam int CHN    = 16;
  localparam int DIV    = 16;
  localparam int SETTLE = 10;
  localparam int HOLDT  = 4;
  localparam int PERIOD = 4 + SETTLE + HOLDT;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          Scan_En = 1'b0;
  logic          Write = 1'b0;
  logic [3:0]    Channel_Select = '0;
  logic [DW-1:0] Wr_Data = '0;
`ifdef DAC_SCAN_READBACK_EN
  logic          Read = 1'b0;
  logic [DW-1:0] Rd_Data;
`endif
  logic          Ack;
  logic          Busy;
  logic [DW-1:0] DAC_DATA;
  logic          DAC_CSn;
  logic          DAC_WRn;
  logic [3:0]    Analog_Switch;
  logic          SH_EN;

  int checks = 0;
  int errors = 0;

  // Reference model: channel timeline derived from tick arithmetic plus a code array
  int            cyc;
  int            t_start;
  int            t_stop;
  int            ch_start;
  int            idle_sw;
  logic [DW-1:0] model_mem [CHN];
  logic [DW-1:0] exp_dac;

  always #5 CLK = ~CLK;

  dac_scan_writer #(
    .DATA_W       (DW),
    .CH_NUM       (CHN),
    .CLK_DIV      (DIV),
    .SETTLE_TICKS (SETTLE),
    .HOLD_TICKS   (HOLDT)
  ) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .Scan_En        (Scan_En),
    .Write          (Write),
    .Channel_Select (Channel_Select),
    .Wr_Data        (Wr_Data),
`ifdef DAC_SCAN_READBACK_EN
    .Read           (Read),
    .Rd_Data        (Rd_Data),
`endif
    .Ack            (Ack),
    .Busy           (Busy),
    .DAC_DATA       (DAC_DATA),
    .DAC_CSn        (DAC_CSn),
    .DAC_WRn        (DAC_WRn),
    .Analog_Switch  (Analog_Switch),
    .SH_EN          (SH_EN)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < CHN; i++) model_mem[i] = '0;
    exp_dac  = '0;
    idle_sw  = 0;
    t_start  = 1;
    t_stop   = 1 << 30;
    ch_start = 0;
    cyc      = 0;
  endtask

  // One clock: drive inputs at the negedge, step an edge, compare with the model
  task automatic cycle(input bit wr, input logic [3:0] ch, input logic [DW-1:0] d);
    int t, k, p, chn;
    logic e_csn, e_wrn, e_sh, e_busy;
    logic [3:0] e_sw;
`ifdef DAC_SCAN_READBACK_EN
    logic rd_now;
    logic [DW-1:0] e_rd;
    rd_now = Read;
`endif
    Write = wr;
    Channel_Select = ch;
    Wr_Data = d;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    Write = 1'b0;
`ifdef DAC_SCAN_READBACK_EN
    Read = 1'b0;
    e_rd = rd_now ? (wr ? d : model_mem[ch]) : '0;
`endif
    t = cyc / DIV;
    if (t >= t_start && t < t_stop) begin
      k   = t - t_start;
      p   = k % PERIOD;
      chn = (ch_start + k / PERIOD) % CHN;
      if ((cyc % DIV) == 0 && p == 1) exp_dac = model_mem[chn];
      e_sw    = 4'(chn);
      e_csn   = !(p == 1 || p == 2);
      e_wrn   = (p != 2);
      e_sh    = (p >= PERIOD - HOLDT);
      e_busy  = 1'b1;
      idle_sw = chn;
    end else begin
      e_sw   = 4'(idle_sw);
      e_csn  = 1'b1;
      e_wrn  = 1'b1;
      e_sh   = 1'b0;
      e_busy = 1'b0;
    end
    if (wr) model_mem[ch] = d;

    checks++;
    if (Ack !== wr) begin
      errors++;
      $display("[TB] FAIL ack cyc=%0d got=%b exp=%b", cyc, Ack, wr);
    end
`ifdef DAC_SCAN_READBACK_EN
    checks++;
    if (Rd_Data !== e_rd) begin
      errors++;
      $display("[TB] FAIL rd_data cyc=%0d got=%h exp=%h", cyc, Rd_Data, e_rd);
    end
`endif
    if ((cyc % DIV) == 0 || (cyc % DIV) == 8 || (cyc % DIV) == DIV - 1) begin
      checks++;
      if (DAC_CSn !== e_csn) begin
        errors++;
        $display("[TB] FAIL csn cyc=%0d got=%b exp=%b", cyc, DAC_CSn, e_csn);
      end
      checks++;
      if (DAC_WRn !== e_wrn) begin
        errors++;
        $display("[TB] FAIL wrn cyc=%0d got=%b exp=%b", cyc, DAC_WRn, e_wrn);
      end
      checks++;
      if (SH_EN !== e_sh) begin
        errors++;
        $display("[TB] FAIL sh_en cyc=%0d got=%b exp=%b", cyc, SH_EN, e_sh);
      end
      checks++;
      if (Busy !== e_busy) begin
        errors++;
        $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, Busy, e_busy);
      end
      checks++;
      if (Analog_Switch !== e_sw) begin
        errors++;
        $display("[TB] FAIL switch cyc=%0d got=%0d exp=%0d", cyc, Analog_Switch, e_sw);
      end
      checks++;
      if (DAC_DATA !== exp_dac) begin
        errors++;
        $display("[TB] FAIL dac_data cyc=%0d got=%h exp=%h", cyc, DAC_DATA, exp_dac);
      end
    end
  endtask

  // Random host traffic avoids channels 3, 5 and 15, which carry directed codes
  task automatic run_until(input int target, input bit rnd);
    while (cyc < target) begin
      if (rnd && $urandom_range(0, 7) == 0) begin
        logic [3:0] c;
        do c = 4'($urandom_range(0, 15)); while (c == 3 || c == 5 || c == 15);
        cycle(1'b1, c, DW'($urandom));
      end else begin
        cycle(1'b0, 4'($urandom_range(0, 15)), DW'($urandom));
      end
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    Scan_En = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (DAC_DATA !== '0)      begin errors++; $display("[TB] FAIL rst_dac got=%h exp=0", DAC_DATA); end
    checks++; if (DAC_CSn !== 1'b1)     begin errors++; $display("[TB] FAIL rst_csn got=%b exp=1", DAC_CSn); end
    checks++; if (DAC_WRn !== 1'b1)     begin errors++; $display("[TB] FAIL rst_wrn got=%b exp=1", DAC_WRn); end
    checks++; if (Analog_Switch !== '0) begin errors++; $display("[TB] FAIL rst_switch got=%0d exp=0", Analog_Switch); end
    checks++; if (SH_EN !== 1'b0)       begin errors++; $display("[TB] FAIL rst_sh got=%b exp=0", SH_EN); end
    checks++; if (Ack !== 1'b0)         begin errors++; $display("[TB] FAIL rst_ack got=%b exp=0", Ack); end
    checks++; if (Busy !== 1'b0)        begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", Busy); end
    RSTn = 1'b1;
    model_reset();
  endtask

  task automatic test_scan_no_writes();
    run_until(40, 1'b0);
    checks++; if (DAC_CSn !== 1'b0) begin errors++; $display("[TB] FAIL ch0_csn got=%b exp=0", DAC_CSn); end
    run_until(56, 1'b0);
    checks++; if (DAC_WRn !== 1'b0) begin errors++; $display("[TB] FAIL ch0_wrn got=%b exp=0", DAC_WRn); end
    checks++; if (DAC_DATA !== '0)  begin errors++; $display("[TB] FAIL ch0_data got=%h exp=0", DAC_DATA); end
    run_until(250, 1'b0);
    checks++; if (SH_EN !== 1'b1)   begin errors++; $display("[TB] FAIL ch0_sh got=%b exp=1", SH_EN); end
    run_until(310, 1'b0);
    checks++; if (Analog_Switch !== 4'd1) begin errors++; $display("[TB] FAIL ch1_switch got=%0d exp=1", Analog_Switch); end
    run_until(600, 1'b0);
    checks++; if (Analog_Switch !== 4'd2) begin errors++; $display("[TB] FAIL ch2_switch got=%0d exp=2", Analog_Switch); end
  endtask

  task automatic test_writes();
    cycle(1'b1, 4'd3, 12'hABC);
    cycle(1'b1, 4'd15, 12'h123);
    cycle(1'b1, 4'd5, 12'h555);
    cycle(1'b0, 4'd0, 12'h000);
    run_until(920, 1'b1);
    checks++; if (DAC_WRn !== 1'b0)       begin errors++; $display("[TB] FAIL ch3_wrn got=%b exp=0", DAC_WRn); end
    checks++; if (Analog_Switch !== 4'd3) begin errors++; $display("[TB] FAIL ch3_switch got=%0d exp=3", Analog_Switch); end
    checks++; if (DAC_DATA !== 12'hABC)   begin errors++; $display("[TB] FAIL ch3_data got=%h exp=abc", DAC_DATA); end
    run_until(4376, 1'b1);
    checks++; if (Analog_Switch !== 4'd15) begin errors++; $display("[TB] FAIL ch15_switch got=%0d exp=15", Analog_Switch); end
    checks++; if (DAC_DATA !== 12'h123)    begin errors++; $display("[TB] FAIL ch15_data got=%h exp=123", DAC_DATA); end
    run_until(4632, 1'b1);
    checks++; if (Analog_Switch !== 4'd0) begin errors++; $display("[TB] FAIL wrap_switch got=%0d exp=0", Analog_Switch); end
  endtask

  task automatic test_collision();
    run_until(6079, 1'b1);
    cycle(1'b1, 4'd5, 12'h9A5);
    run_until(6104, 1'b1);
    checks++; if (DAC_DATA !== 12'h555) begin errors++; $display("[TB] FAIL collide_old got=%h exp=555", DAC_DATA); end
    run_until(10712, 1'b1);
    checks++; if (DAC_DATA !== 12'h9A5) begin errors++; $display("[TB] FAIL collide_new got=%h exp=9a5", DAC_DATA); end
  endtask

  task automatic test_park_resume();
    run_until(11364, 1'b1);
    Scan_En = 1'b0;
    t_stop = 721;
    run_until(11544, 1'b1);
    checks++; if (Busy !== 1'b0)          begin errors++; $display("[TB] FAIL park_busy got=%b exp=0", Busy); end
    checks++; if (DAC_CSn !== 1'b1)       begin errors++; $display("[TB] FAIL park_csn got=%b exp=1", DAC_CSn); end
    checks++; if (Analog_Switch !== 4'd7) begin errors++; $display("[TB] FAIL park_switch got=%0d exp=7", Analog_Switch); end
    run_until(11700, 1'b1);
    Scan_En  = 1'b1;
    t_start  = 732;
    ch_start = 8;
    t_stop   = 1 << 30;
    run_until(11720, 1'b1);
    checks++; if (Analog_Switch !== 4'd8) begin errors++; $display("[TB] FAIL resume_switch got=%0d exp=8", Analog_Switch); end
    checks++; if (Busy !== 1'b1)          begin errors++; $display("[TB] FAIL resume_busy got=%b exp=1", Busy); end
  endtask

  task automatic test_reset_mid_strobe();
    run_until(12324, 1'b1);
    checks++; if (DAC_WRn !== 1'b0)        begin errors++; $display("[TB] FAIL pre_rst_wrn got=%b exp=0", DAC_WRn); end
    checks++; if (Analog_Switch !== 4'd10) begin errors++; $display("[TB] FAIL pre_rst_switch got=%0d exp=10", Analog_Switch); end
    #2 RSTn = 1'b0;
    #1;
    checks++; if (DAC_WRn !== 1'b1) begin errors++; $display("[TB] FAIL arst_wrn got=%b exp=1", DAC_WRn); end
    checks++; if (DAC_CSn !== 1'b1) begin errors++; $display("[TB] FAIL arst_csn got=%b exp=1", DAC_CSn); end
    checks++; if (SH_EN !== 1'b0)   begin errors++; $display("[TB] FAIL arst_sh got=%b exp=0", SH_EN); end
    checks++; if (DAC_DATA !== '0)  begin errors++; $display("[TB] FAIL arst_dac got=%h exp=0", DAC_DATA); end
    checks++; if (Busy !== 1'b0)    begin errors++; $display("[TB] FAIL arst_busy got=%b exp=0", Busy); end
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    model_reset();
    run_until(2936, 1'b0);
    checks++; if (Analog_Switch !== 4'd10) begin errors++; $display("[TB] FAIL post_rst_switch got=%0d exp=10", Analog_Switch); end
    checks++; if (DAC_DATA !== '0)         begin errors++; $display("[TB] FAIL post_rst_data got=%h exp=0", DAC_DATA); end
    run_until(16 * (1 + PERIOD * CHN) + 16, 1'b0);
  endtask

`ifdef DAC_SCAN_READBACK_EN
  task automatic test_readback();
    cycle(1'b1, 4'd2, 12'h7FF);
    Read = 1'b1;
    cycle(1'b0, 4'd2, 12'h000);
    checks++; if (Rd_Data !== 12'h7FF) begin errors++; $display("[TB] FAIL rb_read got=%h exp=7ff", Rd_Data); end
    cycle(1'b0, 4'd2, 12'h000);
    checks++; if (Rd_Data !== '0) begin errors++; $display("[TB] FAIL rb_idle got=%h exp=0", Rd_Data); end
    Read = 1'b1;
    cycle(1'b1, 4'd2, 12'h001);
    checks++; if (Rd_Data !== 12'h001) begin errors++; $display("[TB] FAIL rb_wfirst got=%h exp=001", Rd_Data); end
    run_until(cyc + 64, 1'b1);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_scan_no_writes();
    test_writes();
    test_collision();
    test_park_resume();
    test_reset_mid_strobe();
`ifdef DAC_SCAN_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_scan_writer.md
Name: dac_scan_writer

Overview:
Multi-channel DAC refresh engine. It is the output-side counterpart of the scanning ADC controller.
- Host writes per-channel 12-bit codes into an internal register file.
- The block continuously scans the channels. For each channel it drives a parallel-bus DAC (CSn/WRn strobes), steers the analog demultiplexer and pulses a sample-and-hold enable.
- Sits between the host register bus and the analog output board.

Parameters:
DATA_W, 12, DAC code width
CH_NUM, 16, number of channels (power of 2, max 16)
CLK_DIV, 16, CLK cycles per scan tick (>=2)
SETTLE_TICKS, 10, ticks waited after DAC latch before S/H enable
HOLD_TICKS, 4, ticks S/H enable held high

Ports:
CLK  in  1  system clock
RSTn  in  1  reset, asynchronous, active-low
Scan_En  in  1  1 = scan runs; 0 = park after current channel
Write  in  1  one-CLK write strobe
Channel_Select  in  4  target channel for Write
Wr_Data  in  DATA_W  code to store
Ack  out  1  one-CLK pulse, write accepted
Busy  out  1  1 while FSM not in IDLE
DAC_DATA  out  DATA_W  DAC parallel data bus
DAC_CSn  out  1  DAC chip select, active-low
DAC_WRn  out  1  DAC write strobe, active-low
Analog_Switch  out  4  demux channel address
SH_EN  out  1  sample-and-hold enable for the addressed channel

Behaviour:
- Reset values: register file all 0; DAC_DATA=0; DAC_CSn=1; DAC_WRn=1; Analog_Switch=0; SH_EN=0; Ack=0; Busy=0; scan index=0; tick counter=0; state=IDLE.
- Single clock domain; no derived clocks. The tick counter counts 0..CLK_DIV-1; tick=1 in the cycle where the count is CLK_DIV-1, then the count wraps to 0.
- Host write: Write=1 at edge N stores Wr_Data into mem[Channel_Select] at edge N, and Ack=1 during cycle N+1.
  - Channel_Select >= CH_NUM: the write is ignored, but Ack still pulses.
  - Back-to-back Writes are all accepted.
  - Writes are never blocked by the scan.
- FSM advances only on tick edges. All outputs are registered and change on the same edge the state is entered.
  - IDLE: CSn=1, WRn=1, SH_EN=0. When tick and Scan_En=1, go to SELECT.
  - SELECT (1 tick): Analog_Switch<=scan index; SH_EN=0.
  - LOAD (1 tick): DAC_DATA<=mem[scan index]; CSn=0.
  - STROBE (1 tick): WRn=0.
  - LATCH (1 tick): WRn=1, CSn=1. DAC_DATA holds.
  - SETTLE (SETTLE_TICKS ticks): a tick counter runs.
  - HOLD (HOLD_TICKS ticks): SH_EN=1. On exit: SH_EN=0 and scan index increments, wrapping CH_NUM-1 -> 0. Next state is SELECT if Scan_En=1, otherwise IDLE.
- Channel period = 4+SETTLE_TICKS+HOLD_TICKS ticks. With defaults this is 18 ticks = 288 CLK.
- Simultaneous host write and LOAD read of the same entry: the scan uses the old value; the new value is output on the next visit.
- Scan_En dropping mid-channel does not abort the channel. The full sequence completes, then the FSM parks in IDLE. The scan index is retained, so resuming continues at the next channel.
- Busy=1 in every state except IDLE.
- RSTn asserted mid-operation: all outputs return to reset values immediately (asynchronous). The register file is cleared.
- Illegal state encoding: go to IDLE with reset output values.

Optional Feature:
- Macro DAC_SCAN_READBACK_EN.
- When defined, adds ports Read in 1 and Rd_Data out DATA_W.
  - Read=1 at edge N gives Rd_Data=mem[Channel_Select] during cycle N+1.
  - Rd_Data is 0 when Read=0.
  - On a simultaneous Write to the same channel, Rd_Data returns the new value (write-first).
- When undefined, these ports and their logic are absent.

Decomposition:
- Package dac_scan_pkg: FSM state enum (IDLE, SELECT, LOAD, STROBE, LATCH, SETTLE, HOLD); default constants for DATA_W, CH_NUM, CLK_DIV, SETTLE_TICKS, HOLD_TICKS.
- One sub-module, scan_tick_gen: parameter CLK_DIV; inputs CLK and RSTn; output tick.
- Register file, host port and FSM stay in the top module.

Test Plan:
- Reset release, Scan_En=1, no writes -> channel 0: CSn low 16 CLK after the first tick, WRn low one tick with DAC_DATA=0; SH_EN high 64 CLK; Analog_Switch steps 0,1,2,...,15,0 with a 288-CLK period.
- Write ch3=0xABC, ch15=0x123 -> Ack pulses once per write, one cycle later; DAC_DATA=0xABC while Analog_Switch=3 and WRn low; 0x123 on channel 15; then wrap to channel 0.
- Write to ch5 on the exact edge LOAD samples ch5 -> that pass outputs the old value; the next pass (4608 CLK later with defaults) outputs the new value.
- Scan_En low during SETTLE of ch7 -> ch7 completes HOLD, FSM goes to IDLE, Busy=0, CSn=1; Scan_En high -> scan resumes at ch8.
- RSTn pulsed low during STROBE -> WRn=1, CSn=1, SH_EN=0, DAC_DATA=0 immediately; after release the scan restarts at ch0 and all codes read as 0.
- DAC_SCAN_READBACK_EN defined: Write ch2=0x7FF, then Read ch2 -> Rd_Data=0x7FF one cycle later; simultaneous Write 0x001 and Read ch2 -> Rd_Data=0x001.
